// File: rtl/rr_arbiter_8_pkg.sv
// Shared widths and FSM encoding for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/decoder_3to8.sv
// Plain 3-to-8 binary to one-hot decoder.
module decoder_3to8 (
  input  logic [2:0] sel,
  output logic [7:0] dec_c
);

  always_comb begin
    dec_c = 8'h00;
    dec_c[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with hold-until-done and a watchdog hold limit.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0] idx_d;
  logic             valid_d;

  logic [IDX_W-1:0] pick;
  logic             found;
  logic [IDX_W-1:0] cand;
  logic             hold_limit;
  logic             release_c;
  logic [N_REQ-1:0] dec_c;

  // First set request at or above ptr, wrapping 7 -> 0.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'(ptr_q + IDX_W'(i));
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign hold_limit = (HOLD_MAX != 0) && (hold_q == HOLD_LAST);
  assign release_c  = done || !req[grant_idx] || hold_limit;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    idx_d   = grant_idx;
    valid_d = grant_valid;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          idx_d   = pick;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d = IDLE;
          ptr_d   = IDX_W'(grant_idx + IDX_W'(1));
          idx_d   = '0;
          valid_d = 1'b0;
          hold_d  = '0;
        end else if (hold_q != '1) begin
          hold_d = CNT_W'(hold_q + CNT_W'(1));
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      grant_idx   <= idx_d;
      grant_valid <= valid_d;
    end
  end

  decoder_3to8 u_dec (
    .sel   (grant_idx),
    .dec_c (dec_c)
  );

  assign grant_onehot = dec_c & {N_REQ{grant_valid}};

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one 8-way resource among 8 requesters.
- Registers a 3-bit winner index and decodes it to a one-hot grant through a 3-to-8 decoder sub-block.
- Sits between requesting blocks and the shared resource.
- Adds hold-until-done handshake, a watchdog hold limit and fair rotation.

Parameters:
- HOLD_MAX, 15, max consecutive cycles one grant may be held before forced release; 0 disables the limit; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: one clock; reset is synchronous and active-low.
- req  input  8  request vector; bit i = requester i.
- done  input  1  current grantee releases the resource this cycle.
- grant_valid  output  1  a grant is active.
- grant_idx  output  3  index of current grantee; 0 when grant_valid=0.
- grant_onehot  output  8  decoded grant_idx, gated by grant_valid; 8'h00 when idle.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, ptr=0, hold_cnt=0.
  - grant_valid=0, grant_idx=0, grant_onehot=8'h00.
  - Takes priority over all other inputs, including mid-grant.
- State IDLE:
  - If req!=0, select the first set bit searching upward from ptr and wrapping 7->0.
  - Register that bit as grant_idx, set grant_valid=1, hold_cnt=0, go to GRANT.
  - If req==0, stay in IDLE with outputs at idle values.
- Latency: req seen at edge N -> grant_valid=1 after edge N+1 samples it, i.e. outputs change one cycle after req.
- State GRANT: release when any of the following holds at a clk edge:
  - done=1;
  - req[grant_idx]=0;
  - HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1.
- Otherwise stay in GRANT and increment hold_cnt, saturating at 15.
- On release:
  - ptr <= grant_idx+1, modulo 8 (7 wraps to 0).
  - grant_valid <= 0, grant_idx <= 0, state <= IDLE.
  - Exactly one idle bubble cycle always separates consecutive grants.
- Simultaneous release causes (done + timeout, done + req drop) give a single release with identical effect.
- done while in IDLE is ignored.
- req bits other than the grantee's are ignored during GRANT.
- grant_onehot is combinational from the registered grant_idx and grant_valid; no extra latency.
- A granted requester holds the resource for at least 1 cycle and at most HOLD_MAX cycles (unbounded when HOLD_MAX=0).
- Fairness: with all 8 requesting continuously, each requester is granted once in every 8 grants.

Decomposition:
- Shared package:
  - N_REQ=8, IDX_W=3;
  - state encoding IDLE=1'b0, GRANT=1'b1;
  - CNT_W=4.
- One sub-module: decoder_3to8, the team's existing 3-to-8 decoder.
  - Instantiated on grant_idx.
  - Its outputs are ANDed with grant_valid to form grant_onehot.
- Rotating priority search and FSM stay in rr_arbiter_8.

Test Plan:
1. Reset hold: rst_n=0 for 2 cycles with req=8'hFF -> grant_valid=0, grant_idx=0, grant_onehot=8'h00 throughout.
2. Single requester: req=8'h20 from cycle N -> cycle N+1 grant_valid=1, grant_idx=5, grant_onehot=8'h20; one-cycle done pulse -> grant_valid=0 next cycle.
3. Rotation and wrap: after reset, req=8'h81 held, done pulsed once per grant.
   - Grants go idx 0, 7, 0, 7, each separated by one bubble cycle.
   - grant_onehot alternates 8'h01/8'h80.
4. Watchdog: HOLD_MAX=4, req=8'h03 held, done=0.
   - idx 0 for exactly 4 cycles, 1 bubble, then idx 1 for exactly 4 cycles, then idx 0 again.
5. Requester drop and simultaneous causes:
   - While granted idx 3, deassert req[3] -> grant_valid=0 next edge, and the next grant with req=8'h18 is idx 4.
   - done and timeout in the same cycle -> a single release, with ptr advancing by exactly one.
6. Reset mid-grant: while granted idx 6, pulse rst_n=0 for one cycle -> outputs zero after that edge; then req=8'hC0 -> grant idx 6 (ptr reset to 0).
